// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared constants and types for the multicycle signed divider.
//   DIV_DATA_W : default operand/result width
//   DIV_CNT_W  : default iteration counter width (must be able to hold DATA_W)
//   DIV_ITERS  : number of restoring iterations, one quotient bit per cycle
//   div_state_e: FSM state encodings shared with anything that decodes them
// ---------------------------------------------------------------------------
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;
  localparam int DIV_ITERS  = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
// Handshake and data bundle between the control unit / operand registers and
// the divider.
//   div_start : one-cycle start pulse from the control unit
//   a_in      : dividend (RegA_out)
//   b_in      : divisor  (RegB_out)
//   hi_out    : remainder, to HI
//   lo_out    : quotient, to LO
//   div_busy  : high while a division is in progress
//   div_done  : one-cycle completion pulse
//   div_zero  : one-cycle divide-by-zero pulse
// master = control side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) ();

  logic              div_start;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              div_busy;
  logic              div_done;
  logic              div_zero;

  modport master (
    output div_start, a_in, b_in,
    input  hi_out, lo_out, div_busy, div_done, div_zero
  );

  modport slave (
    input  div_start, a_in, b_in,
    output hi_out, lo_out, div_busy, div_done, div_zero
  );

endinterface

// File: rtl/div_unit_twos_neg.sv
// ---------------------------------------------------------------------------
// twos_neg
// Combinational conditional two's-complement negate. Used for taking the
// magnitude of signed operands (i_neg = sign bit) and for re-applying a sign
// to an unsigned result. Written generically so a multiplier can reuse it.
//   i_val : value to (maybe) negate
//   i_neg : 1 = output -i_val, 0 = pass i_val through
//   o_val : result, same width as i_val
// Note: the magnitude of the most negative value is itself, which reads
// correctly as the unsigned value 2^(W-1).
// ---------------------------------------------------------------------------
module twos_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Multicycle signed divider for DIV using restoring division, one quotient bit
// per clock. Quotient truncates toward zero, remainder takes the dividend's
// sign. A start pulse in IDLE with a non-zero divisor begins a division;
// results and a div_done pulse appear DATA_W+1 edges after the start edge.
// A zero divisor raises div_zero for one cycle instead and leaves HI/LO alone.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : div_unit_if slave (start/operands in, HI/LO/status out)
// ---------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  // One iteration per result bit.
  localparam int ITERS = DATA_W;

  div_state_e        r_state;
  div_state_e        w_nextState;

  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_div;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_signQ;
  logic              r_signR;
  logic              r_done;
  logic              r_zero;

  logic [DATA_W-1:0] w_absA;
  logic [DATA_W-1:0] w_absB;
  logic [DATA_W-1:0] w_loFinal;
  logic [DATA_W-1:0] w_hiFinal;
  logic [DATA_W:0]   w_remShift;
  logic [DATA_W:0]   w_diff;
  logic              w_bZero;
  logic              w_lastIter;

  // Magnitudes of the incoming operands, taken only at the start edge.
  twos_neg #(.W(DATA_W)) u_absA (
    .i_val (bus.a_in),
    .i_neg (bus.a_in[DATA_W-1]),
    .o_val (w_absA)
  );

  twos_neg #(.W(DATA_W)) u_absB (
    .i_val (bus.b_in),
    .i_neg (bus.b_in[DATA_W-1]),
    .o_val (w_absB)
  );

  // Sign correction of the unsigned quotient/remainder at the FIX step.
  twos_neg #(.W(DATA_W)) u_fixLo (
    .i_val (r_quo),
    .i_neg (r_signQ),
    .o_val (w_loFinal)
  );

  twos_neg #(.W(DATA_W)) u_fixHi (
    .i_val (r_rem),
    .i_neg (r_signR),
    .o_val (w_hiFinal)
  );

  assign w_bZero    = (bus.b_in == '0);
  assign w_lastIter = (r_cnt == CNT_W'(ITERS - 1));

  // The remainder stays below the divisor (at most 2^(DATA_W-1)), so the
  // shifted value fits in DATA_W bits and bit DATA_W of the difference is a
  // true borrow/sign bit.
  assign w_remShift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff     = w_remShift - {1'b0, r_div};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Starts are only honoured in IDLE, which makes a start
  // in the div_done cycle legal and one during RUN/FIX a no-op.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      DIV_IDLE: if (bus.div_start && !w_bZero) w_nextState = DIV_RUN;
      DIV_RUN:  if (w_lastIter)                w_nextState = DIV_FIX;
      DIV_FIX:                                 w_nextState = DIV_IDLE;
      default:                                 w_nextState = DIV_IDLE;
    endcase
  end

  // Datapath. Operands are captured as magnitudes plus result signs, the
  // restoring loop runs on the unsigned values, and HI/LO are only written
  // at FIX so an aborted or in-flight division never shows a partial result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_cnt   <= '0;
      r_signQ <= 1'b0;
      r_signR <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_zero <= 1'b0;
      unique case (r_state)
        DIV_IDLE: begin
          if (bus.div_start) begin
            if (w_bZero) begin
              r_zero <= 1'b1;
            end else begin
              r_quo   <= w_absA;
              r_div   <= w_absB;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_signQ <= bus.a_in[DATA_W-1] ^ bus.b_in[DATA_W-1];
              r_signR <= bus.a_in[DATA_W-1];
            end
          end
        end
        DIV_RUN: begin
          if (!w_diff[DATA_W]) begin
            r_rem <= w_diff[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
          end else begin
            r_rem <= w_remShift[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          r_lo   <= w_loFinal;
          r_hi   <= w_hiFinal;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;
  assign bus.div_busy = (r_state != DIV_IDLE);
  assign bus.div_done = r_done;
  assign bus.div_zero = r_zero;

  // Completion and divide-by-zero are mutually exclusive by construction.
  doneZeroExclusive: assert property (@(posedge clk) disable iff (!reset)
    !(r_done && r_zero));

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Directed, table-driven bench for div_unit plus hand-written sequences for
// divide-by-zero, reset mid-division, start held during RUN and a start in
// the div_done cycle. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int LATENCY = 33;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, prints a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Pulses start with the given operands (caller is #1 after a posedge),
  // checks busy right after the start edge, then waits a bounded number of
  // edges for div_done. Returns the edge count to done (-1 on timeout) and
  // whether div_zero was seen on the way. Leaves time inside the done cycle.
  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, output int lat,
                               output logic zeroSeen);
    bus.a_in      = a;
    bus.b_in      = b;
    bus.div_start = 1'b1;
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    checkOutput({name, " busy after start"}, {31'b0, bus.div_busy}, 32'd1);
    lat      = -1;
    zeroSeen = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (bus.div_zero) zeroSeen = 1'b1;
      if (bus.div_done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    int   lat;
    int   lat2;
    logic zeroSeen;
    logic doneSeen;

    checks = 0;
    errors = 0;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[4]  = '{32'd100,      32'd7,        32'd14,       32'd2};
    vecs[5]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    vecs[6]  = '{32'd0,        32'd5,        32'd0,        32'd0};
    vecs[7]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    vecs[8]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        32'd0};
    vecs[10] = '{32'h12345678, 32'd16,       32'h01234567, 32'd8};
    vecs[11] = '{32'd9,        32'd4,        32'd2,        32'd1};

    bus.div_start = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    reset         = 1'b0;

    // Reset state.
    #1;
    checkOutput("reset lo",   bus.lo_out, 32'd0);
    checkOutput("reset hi",   bus.hi_out, 32'd0);
    checkOutput("reset busy", {31'b0, bus.div_busy}, 32'd0);
    checkOutput("reset done", {31'b0, bus.div_done}, 32'd0);
    checkOutput("reset zero", {31'b0, bus.div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table of normal divisions.
    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, lat, zeroSeen);
      checkOutput($sformatf("vec%0d latency", i), lat, LATENCY);
      checkOutput($sformatf("vec%0d lo", i), bus.lo_out, vecs[i].expLo);
      checkOutput($sformatf("vec%0d hi", i), bus.hi_out, vecs[i].expHi);
      checkOutput($sformatf("vec%0d zero", i), {31'b0, zeroSeen}, 32'd0);
      checkOutput($sformatf("vec%0d busy in done", i), {31'b0, bus.div_busy}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d done pulse width", i), {31'b0, bus.div_done}, 32'd0);
    end

    // Divide by zero after 9/4 left lo=2, hi=1.
    bus.a_in      = 32'd5;
    bus.b_in      = 32'd0;
    bus.div_start = 1'b1;
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    checkOutput("div0 zero", {31'b0, bus.div_zero}, 32'd1);
    checkOutput("div0 busy", {31'b0, bus.div_busy}, 32'd0);
    checkOutput("div0 done", {31'b0, bus.div_done}, 32'd0);
    checkOutput("div0 lo",   bus.lo_out, 32'd2);
    checkOutput("div0 hi",   bus.hi_out, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("div0 zero width", {31'b0, bus.div_zero}, 32'd0);
    doneSeen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.div_done || bus.div_busy) doneSeen = 1'b1;
    end
    checkOutput("div0 no done/busy", {31'b0, doneSeen}, 32'd0);

    // Reset ten edges into a division clears everything immediately.
    bus.a_in      = 32'd1000;
    bus.b_in      = 32'd3;
    bus.div_start = 1'b1;
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", {31'b0, bus.div_busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midreset lo",   bus.lo_out, 32'd0);
    checkOutput("midreset hi",   bus.hi_out, 32'd0);
    checkOutput("midreset busy", {31'b0, bus.div_busy}, 32'd0);
    checkOutput("midreset done", {31'b0, bus.div_done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midreset busy held", {31'b0, bus.div_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("rearm", 32'd100, 32'd7, lat, zeroSeen);
    checkOutput("rearm latency", lat, LATENCY);
    checkOutput("rearm lo", bus.lo_out, 32'd14);
    checkOutput("rearm hi", bus.hi_out, 32'd2);
    @(posedge clk);
    #1;

    // Start held high through RUN with different operands is ignored.
    bus.a_in      = 32'd50;
    bus.b_in      = 32'd5;
    bus.div_start = 1'b1;
    @(posedge clk);
    #1;
    bus.a_in = 32'd99;
    bus.b_in = 32'd2;
    lat = -1;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (n == 20) bus.div_start = 1'b0;
      if (bus.div_done) begin
        lat = n;
        break;
      end
    end
    bus.div_start = 1'b0;
    checkOutput("held latency", lat, LATENCY);
    checkOutput("held lo", bus.lo_out, 32'd10);
    checkOutput("held hi", bus.hi_out, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: second start issued in the first div_done cycle.
    applyStimulus("b2b first", 32'd20, 32'd3, lat, zeroSeen);
    checkOutput("b2b first latency", lat, LATENCY);
    checkOutput("b2b first lo", bus.lo_out, 32'd6);
    checkOutput("b2b first hi", bus.hi_out, 32'd2);
    applyStimulus("b2b second", 32'd21, 32'd4, lat2, zeroSeen);
    checkOutput("b2b second latency", lat2, LATENCY);
    checkOutput("b2b second lo", bus.lo_out, 32'd5);
    checkOutput("b2b second hi", bus.hi_out, 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for DIV. Sits downstream of the A/B operand registers and upstream of the HI/LO inputs of the register-write-data mux.
- Started by the control unit with a one-cycle pulse; reports completion and divide-by-zero back to the control unit.
- Implements restoring division, one quotient bit per cycle, with MIPS semantics: quotient truncated toward zero, remainder takes the sign of the dividend.

Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 6, iteration counter width (must hold DATA_W)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- div_start  in  1  start pulse from control unit
- a_in  in  DATA_W  dividend (RegA_out)
- b_in  in  DATA_W  divisor (RegB_out)
- hi_out  out  DATA_W  remainder, to HI
- lo_out  out  DATA_W  quotient, to LO
- div_busy  out  1  high while a division is in progress
- div_done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle divide-by-zero exception pulse

Behaviour:
- Reset: one clock; reset is asynchronous, active-low. While reset=0, state=IDLE and hi_out, lo_out, div_busy, div_done, div_zero and all internal registers are 0. Reset mid-division aborts it; no partial result is ever presented.
- States: IDLE, RUN, FIX.
- IDLE:
  - div_start=1 and b_in!=0 at edge E0: latch |a_in| into the quotient shift register and |b_in| into the divisor register. Clear the remainder accumulator and counter. Record sign_q = a[31]^b[31] and sign_r = a[31]. Go to RUN; div_busy=1.
  - div_start=1 and b_in==0 at edge E0: div_zero=1 for the cycle after E0. Stay in IDLE; div_busy stays 0; hi_out/lo_out unchanged.
- RUN, edges E0+1..E0+32:
  - Shift {rem,quo} left by 1 and trial-subtract the divisor from rem (DATA_W+1-bit subtract).
  - If non-negative: keep the difference and set quo[0]=1. Otherwise restore rem and set quo[0]=0.
  - Counter increments; after the 32nd iteration go to FIX.
- FIX, edge E0+33:
  - lo_out = sign_q ? -quo : quo; hi_out = sign_r ? -rem : rem.
  - div_done=1 for exactly one cycle, div_busy=0, return to IDLE.
- Total latency: results valid and div_done high in the cycle after edge E0+33.
- Absolute value of 0x80000000 is 0x80000000, treated as unsigned 2^31. 0x80000000 / -1 gives lo=0x80000000, hi=0 (wrap, no exception).
- div_start while busy (RUN/FIX) is ignored.
- div_start in the cycle where div_done=1 is accepted, since the state is already IDLE.
- hi_out/lo_out hold their last values between operations and during RUN; they are written only at FIX.
- a_in/b_in may change after E0 without effect.
- div_done and div_zero are never high together.

Decomposition:
- Shared header (`define file) holds:
  - state encodings DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_FIX=2'd2
  - DATA_W default
  - iteration count constant DIV_ITERS=32
- No sub-module is required. A small combinational abs/negate helper (name: twos_neg) is optional and reusable by a later mult_unit.

Test Plan:
- a=7, b=2, start at E0 -> div_busy=1 from E0, div_done pulse after E0+33, lo=3, hi=1.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Divide by zero: first a=9, b=4 (lo=2, hi=1), then a=5, b=0 -> div_zero=1 for one cycle after the sampling edge, div_busy=0, lo/hi stay 2/1, no div_done.
- Reset and re-arm:
  - Assert reset=0 at E0+10 of a division -> all outputs 0 immediately, state IDLE.
  - Release reset, start a=100, b=7 -> lo=14, hi=2 after 33 edges.
- Start handling:
  - div_start held high during RUN with different operands -> ignored, original result returned.
  - div_start asserted in the div_done cycle -> new division begins, with its next done exactly 33 edges later.
